// File: rtl/i2c_write_master_pkg.sv
// Shared definitions for the I2C write initiator: FSM encoding, default target
// address and the helper that forms the address+W byte.
package i2c_write_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BYTE  = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h47;
  localparam logic [1:0] LAST_BYTE        = 2'd2;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev);
    return {dev, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_write_master_if.sv
// Request/status handshake plus open-drain pad controls of the write initiator.
interface i2c_write_master_if;
  logic       start;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       sda_i;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (
    input  start, reg_addr, wdata, sda_i,
    output scl_oe, sda_oe, busy, done, ack_err
  );

  modport slave (
    output start, reg_addr, wdata, sda_i,
    input  scl_oe, sda_oe, busy, done, ack_err
  );
endinterface

// File: rtl/i2c_quarter_tick.sv
// Quarter-period strobe: one-cycle tick every CLK_DIV clocks, held at phase 0
// while clear is asserted.
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  logic [7:0] div_r;
  logic       wrap_s;

  assign wrap_s = (div_r == 8'(CLK_DIV - 1));
  assign tick   = wrap_s & ~clear;

  // Free-running divider restarted whenever the initiator is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= 8'd0;
    end else if (clear || wrap_s) begin
      div_r <= 8'd0;
    end else begin
      div_r <= div_r + 8'd1;
    end
  end
endmodule

// File: rtl/i2c_write_master.sv
// I2C write initiator: START, address+W, register byte, data byte, STOP, with
// ACK sampling after every byte and abort-to-STOP on NACK.
module i2c_write_master
  import i2c_write_master_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 25,
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  i2c_write_master_if.master bus
);
  state_t     state_r;
  logic [1:0] q_r;
  logic [2:0] bit_cnt_r;
  logic [1:0] byte_cnt_r;
  logic [7:0] shift_r;
  logic [7:0] reg_addr_r;
  logic [7:0] wdata_r;
  logic       qstart_r;
  logic       scl_oe_r;
  logic       sda_oe_r;
  logic       busy_r;
  logic       done_r;
  logic       ack_err_r;

  logic       tick_s;
  logic       clear_s;
  logic       nack_s;
  logic       abort_s;
  logic [7:0] next_byte_s;

  assign clear_s = (state_r == ST_IDLE);

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // ACK sampled on the first cycle of Q3; abort must also see a same-cycle NACK.
  always_comb begin
    nack_s      = 1'b0;
    next_byte_s = wdata_r;
    if (state_r == ST_ACK && q_r == 2'd3 && qstart_r && bus.sda_i) begin
      nack_s = 1'b1;
    end else begin
      nack_s = 1'b0;
    end
    if (byte_cnt_r == 2'd0) begin
      next_byte_s = reg_addr_r;
    end else begin
      next_byte_s = wdata_r;
    end
  end

  assign abort_s = ack_err_r | nack_s;

  // Frame sequencer with registered pad controls and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      q_r        <= 2'd0;
      bit_cnt_r  <= 3'd7;
      byte_cnt_r <= 2'd0;
      shift_r    <= 8'd0;
      reg_addr_r <= 8'd0;
      wdata_r    <= 8'd0;
      qstart_r   <= 1'b0;
      scl_oe_r   <= 1'b0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ack_err_r  <= 1'b0;
    end else begin
      qstart_r <= tick_s;
      done_r   <= 1'b0;
      if (nack_s) begin
        ack_err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            shift_r    <= addr_byte(DEV_ADDR);
            reg_addr_r <= bus.reg_addr;
            wdata_r    <= bus.wdata;
            ack_err_r  <= 1'b0;
            busy_r     <= 1'b1;
            scl_oe_r   <= 1'b0;
            sda_oe_r   <= 1'b1;
            q_r        <= 2'd0;
            bit_cnt_r  <= 3'd7;
            byte_cnt_r <= 2'd0;
            state_r    <= ST_START;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (q_r == 2'd1) begin
              q_r      <= 2'd0;
              scl_oe_r <= 1'b1;
              sda_oe_r <= ~shift_r[7];
              state_r  <= ST_BYTE;
            end else begin
              q_r <= q_r + 2'd1;
            end
          end
        end
        ST_BYTE: begin
          if (tick_s) begin
            q_r <= q_r + 2'd1;
            if (q_r == 2'd1) begin
              scl_oe_r <= 1'b0;
            end
            if (q_r == 2'd3) begin
              scl_oe_r <= 1'b1;
              if (bit_cnt_r == 3'd0) begin
                sda_oe_r <= 1'b0;
                state_r  <= ST_ACK;
              end else begin
                bit_cnt_r <= bit_cnt_r - 3'd1;
                shift_r   <= {shift_r[6:0], 1'b0};
                sda_oe_r  <= ~shift_r[6];
              end
            end
          end
        end
        ST_ACK: begin
          if (tick_s) begin
            q_r <= q_r + 2'd1;
            if (q_r == 2'd1) begin
              scl_oe_r <= 1'b0;
            end
            if (q_r == 2'd3) begin
              scl_oe_r <= 1'b1;
              if (abort_s || byte_cnt_r == LAST_BYTE) begin
                sda_oe_r <= 1'b1;
                state_r  <= ST_STOP;
              end else begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                bit_cnt_r  <= 3'd7;
                shift_r    <= next_byte_s;
                sda_oe_r   <= ~next_byte_s[7];
                state_r    <= ST_BYTE;
              end
            end
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            q_r <= q_r + 2'd1;
            if (q_r == 2'd1) begin
              scl_oe_r <= 1'b0;
            end
            if (q_r == 2'd2) begin
              sda_oe_r <= 1'b0;
            end
            if (q_r == 2'd3) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          scl_oe_r <= 1'b0;
          sda_oe_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.scl_oe  = scl_oe_r;
  assign bus.sda_oe  = sda_oe_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.ack_err = ack_err_r;
endmodule
